// File: rtl/rda_sum_stage.sv
// Final sum stage of a radix prefix adder: turns resolved carry symbols plus the
// delayed operands into sum/cout/ovf, buffered through a two-entry skid output.
module rda_sum_stage #(
  parameter logic [7:0] KILL_CODE = 8'd0,
  parameter logic [7:0] PROP_CODE = 8'd1,
  parameter logic [7:0] GEN_CODE  = 8'd2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0][7:0] y,
  input  logic [31:0]      c,
  input  logic [31:0]      d,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [31:0]      sum,
  output logic             cout,
  output logic             ovf,
  output logic             sym_err,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             drop
);

  // state | meaning
  // EMPTY | no result held, outputs invalid
  // ONE   | MAIN holds the oldest result, SKID unused
  // TWO   | MAIN holds the oldest result, SKID holds the next one
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;

  typedef struct packed {
    logic [31:0] sum;
    logic        cout;
    logic        ovf;
    logic        sym_err;
  } res_t;

  state_t      state;
  res_t        main_q, skid_q, res_d;
  logic [31:0] carry_in;
  logic        accept, pop;

  always_comb begin
    carry_in = '0;
    res_d    = '0;
    for (int i = 1; i < 32; i++)
      carry_in[i] = (y[i-1] == GEN_CODE);
    res_d.sum  = c ^ d ^ carry_in;
    res_d.cout = (y[31] == GEN_CODE);
    res_d.ovf  = carry_in[31] ^ res_d.cout;
    // An unresolved propagate is the common failure, but any non-kill/non-gen code is an error.
    for (int i = 0; i < 32; i++)
      if ((y[i] == PROP_CODE) || ((y[i] != KILL_CODE) && (y[i] != GEN_CODE)))
        res_d.sym_err = 1'b1;
  end

  assign accept = in_valid && in_ready;
  assign pop    = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= EMPTY;
      main_q    <= '0;
      skid_q    <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      drop      <= 1'b0;
    end else begin
      // Upstream cannot stall, so a beat offered while full is lost for good.
      if (in_valid && !in_ready)
        drop <= 1'b1;
      case (state)
        EMPTY: begin
          if (accept) begin
            main_q    <= res_d;
            state     <= ONE;
            out_valid <= 1'b1;
          end
        end
        ONE: begin
          if (accept && !pop) begin
            skid_q   <= res_d;
            state    <= TWO;
            in_ready <= 1'b0;
          end else if (!accept && pop) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
          end else if (accept && pop) begin
            main_q <= res_d;
          end
        end
        TWO: begin
          if (pop) begin
            main_q   <= skid_q;
            state    <= ONE;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state     <= EMPTY;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign sum     = main_q.sum;
  assign cout    = main_q.cout;
  assign ovf     = main_q.ovf;
  assign sym_err = main_q.sym_err;

endmodule
